icache_dm: RTL and testbench



---
 rtl/icache_dm.sv | 138 +++++++++++++
 tb/tb_icache_dm.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, single-word-block instruction cache.
// Serves fetch reads from a 2^IIDX_W entry tag/data array and runs
// single-word fills through the memory controller's instruction port.
// A flush input invalidates every entry at once.
// Optional feature macro: ICACHE_STATS_EN adds 32-bit hit/miss counters;
// without it hit_count and miss_count are tied to zero.
module icache_dm #(
    parameter int WORD_W = 32,
    parameter int ITAG_W = 26,
    parameter int IIDX_W = 4,
    parameter int IBYT_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [31:0]       imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [31:0]       iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    input  logic              flush,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int DEPTH = 1 << IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t            state;
    icachef_t          req;
    logic [DEPTH-1:0]  valid;
    logic [ITAG_W-1:0] tag_mem  [DEPTH];
    logic [WORD_W-1:0] data_mem [DEPTH];
    logic [ITAG_W-1:0] miss_tag;
    logic [IIDX_W-1:0] miss_idx;
    logic              lookup_hit;
    logic              start_miss;
    logic              fill_done;
    logic              unused_bytoff;

    assign req = icachef_t'(imemaddr);

    // The byte offset never takes part in the lookup of a single-word block.
    assign unused_bytoff = ^req.bytoff;

    assign lookup_hit = valid[req.idx] && (tag_mem[req.idx] == req.tag);
    assign ihit       = imemREN && (state == IDLE) && lookup_hit;
    assign imemload   = data_mem[req.idx];

    // A flush in IDLE suppresses the miss so the freshly cleared array is
    // looked up again next cycle instead of refilling a stale request.
    assign start_miss = (state == IDLE) && imemREN && !lookup_hit && !flush;
    assign fill_done  = (state == FETCH) && !iwait;
    assign iaddr      = {miss_tag, miss_idx, {IBYT_W{1'b0}}};

    // Miss FSM: latches the missing line and holds iREN through the fill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            iREN     <= 1'b0;
            miss_tag <= '0;
            miss_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_miss) begin
                        state    <= FETCH;
                        iREN     <= 1'b1;
                        miss_tag <= req.tag;
                        miss_idx <= req.idx;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        state <= IDLE;
                        iREN  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    iREN  <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: flush clears everything and beats a completing fill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[miss_idx] <= 1'b1;
        end
    end

    // Tag/data storage is written on fill completion and is never reset.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    // Performance counters: hits per cycle, misses per IDLE->FETCH entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: scoreboard bench for icache_dm. A transaction-level model
// (map of cached word addresses plus one pending fill) predicts hits and
// fill windows; a monitor pops those predictions when the DUT shows them.
// Honours ICACHE_STATS_EN for the expected counter values.
module tb_icache_dm;

`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_dm dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .flush      (flush),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } hit_t;

    typedef struct {
        int          start_c;
        int          end_c;
        logic [31:0] addr;
    } fill_t;

    hit_t  hit_q[$];
    fill_t fill_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: which word address each index holds, plus one pending fill.
    bit          m_valid [16];
    logic [29:0] m_line  [16];
    logic [31:0] m_data  [16];
    bit          m_busy;
    logic [29:0] m_pend;
    int          m_start;
    int          m_hits;
    int          m_misses;
    int          shown_hits;
    int          shown_misses;

    bit ren_prev = 1'b0;
    int span_start = 0;
    logic [31:0] span_addr = '0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory contents: any word address maps to a fixed pseudo-random word;
    // word 0x10 (byte address 0x40) returns 0x2401000A.
    function automatic logic [31:0] memWord(input logic [29:0] w);
        return 32'h2401000A ^ (({2'b00, w} - 32'h10) * 32'h9E3779B1);
    endfunction

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void clearModel();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_busy   = 1'b0;
        m_pend   = '0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // Drive one cycle of inputs and advance the reference model across the next edge.
    task automatic applyStimulus(input bit ren, input logic [31:0] addr,
                                 input bit fl, input bit wt);
        logic [29:0] word;
        logic [3:0]  idx;
        bit          hit;
        @(posedge CLK);
        #1;
        imemREN  = ren;
        imemaddr = addr;
        flush    = fl;
        iwait    = wt;
        iload    = m_busy ? memWord(m_pend) : $urandom;
        word = addr[31:2];
        idx  = word[3:0];
        hit  = ren && !m_busy && m_valid[idx] && (m_line[idx] == word);
        shown_hits   = m_hits;
        shown_misses = m_misses;
        if (hit) begin
            hit_q.push_back('{cyc, addr, m_data[idx]});
            m_hits++;
        end
        if (m_busy && !wt) begin
            m_line[m_pend[3:0]]  = m_pend;
            m_data[m_pend[3:0]]  = memWord(m_pend);
            m_valid[m_pend[3:0]] = 1'b1;
            fill_q.push_back('{m_start, cyc, {m_pend, 2'b00}});
            m_busy = 1'b0;
        end else if (!m_busy && ren && !hit && !fl) begin
            m_busy  = 1'b1;
            m_pend  = word;
            m_start = cyc + 1;
            m_misses++;
        end
        if (fl) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end
    endtask

    // Request a line until its fill completes; the next cycle can hit it.
    task automatic fetchLine(input logic [31:0] addr, input int waits);
        applyStimulus(1'b1, addr, 1'b0, 1'b1);
        for (int i = 0; i < waits; i++) applyStimulus(1'b1, addr, 1'b0, 1'b1);
        applyStimulus(1'b1, addr, 1'b0, 1'b0);
    endtask

    task automatic checkNow(input string name, input logic [31:0] act_sel_dummy,
                            input logic [31:0] exp);
        checkOutput(name, act_sel_dummy, exp);
    endtask

    task automatic checkCounters(input string name);
        @(negedge CLK);
        checkOutput({name, "_hits"}, hit_count, STATS ? shown_hits : 0);
        checkOutput({name, "_misses"}, miss_count, STATS ? shown_misses : 0);
    endtask

    // Assert reset in the middle of a cycle; iREN must fall before the next edge.
    task automatic doReset();
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
        flush   = 1'b0;
        iwait   = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        checkOutput("rst_iren_async", {31'd0, iREN}, 32'd0);
        if (m_busy) fill_q.push_back('{m_start, cyc - 1, {m_pend, 2'b00}});
        clearModel();
        @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    // Monitor: pops predicted hits and fill windows when the DUT shows them.
    always @(negedge CLK) begin
        if (ihit === 1'b1) begin
            if (hit_q.size() == 0) begin
                checkOutput("unexpected_hit", imemaddr, 32'hFFFFFFFF);
            end else begin
                hit_t h;
                h = hit_q.pop_front();
                checkOutput("hit_cycle", cyc, h.cyc);
                checkOutput("hit_data", imemload, h.data);
            end
        end
        if (iREN === 1'b1 && !ren_prev) begin
            span_start = cyc;
            span_addr  = iaddr;
        end
        if (iREN !== 1'b1 && ren_prev) begin
            if (fill_q.size() == 0) begin
                checkOutput("unexpected_fill", span_addr, 32'hFFFFFFFF);
            end else begin
                fill_t f;
                f = fill_q.pop_front();
                checkOutput("fill_start", span_start, f.start_c);
                checkOutput("fill_end", cyc - 1, f.end_c);
                checkOutput("fill_addr", span_addr, f.addr);
            end
        end
        ren_prev = (iREN === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RST = 1'b0;
        imemREN = 1'b0;
        imemaddr = '0;
        flush = 1'b0;
        iwait = 1'b1;
        iload = '0;
        clearModel();
        #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_ihit", {31'd0, ihit}, 32'd0);
        checkOutput("reset_iren", {31'd0, iREN}, 32'd0);
        checkOutput("reset_iaddr", iaddr, 32'd0);
        checkOutput("reset_hit_count", hit_count, 32'd0);
        checkOutput("reset_miss_count", miss_count, 32'd0);
        @(posedge CLK);
        #2;
        RST = 1'b0;

        // Cold miss on 0x40 with three wait cycles.
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("cold_c0_ihit", {31'd0, ihit}, 32'd0);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("cold_c1_iren", {31'd0, iREN}, 32'd1);
        checkOutput("cold_c1_iaddr", iaddr, 32'h40);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("cold_hit", {31'd0, ihit}, 32'd1);
        checkOutput("cold_data", imemload, 32'h2401000A);
        checkOutput("cold_miss_count", miss_count, STATS ? 32'd1 : 32'd0);

        // Conflict eviction at index 0.
        applyStimulus(1'b1, 32'h440, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("conflict_440_miss", {31'd0, ihit}, 32'd0);
        applyStimulus(1'b1, 32'h440, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h440, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("conflict_40_remiss", {31'd0, ihit}, 32'd0);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("conflict_miss_count", miss_count, STATS ? 32'd3 : 32'd0);

        // Address change during a fill.
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h84, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("addrchg_iaddr", iaddr, 32'h80);
        applyStimulus(1'b1, 32'h84, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h84, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("addrchg_84_miss", {31'd0, ihit}, 32'd0);
        applyStimulus(1'b1, 32'h84, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("addrchg_80_hit", {31'd0, ihit}, 32'd1);
        checkOutput("addrchg_80_noiren", {31'd0, iREN}, 32'd0);

        // Flush, then flush coinciding with fill completion.
        fetchLine(32'h10, 0);
        fetchLine(32'h14, 1);
        applyStimulus(1'b0, 32'h10, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("flush_10_miss", {31'd0, ihit}, 32'd0);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("flush_14_miss", {31'd0, ihit}, 32'd0);
        applyStimulus(1'b1, 32'h14, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("flush_fill_invalid", {31'd0, ihit}, 32'd0);
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b1);

        // Reset in the middle of a fill, then five hits.
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
        doReset();
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("rst_entry_invalid", {31'd0, ihit}, 32'd0);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h200, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("stats_hit5", hit_count, STATS ? 32'd5 : 32'd0);
        checkOutput("stats_miss1", miss_count, STATS ? 32'd1 : 32'd0);

        // Randomized traffic over a small address pool to force reuse and conflicts.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            a = ({30'd0, 2'($urandom_range(0, 2))} << 6)
              | ({28'd0, 4'($urandom_range(0, 15))} << 2)
              | {30'd0, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) a = a | 32'hFFFF_F000;
            applyStimulus($urandom_range(0, 9) < 8, a, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 1) == 1);
            if (n % 250 == 249) checkCounters("random");
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkCounters("final");
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("hit_queue_drained", hit_q.size(), 32'd0);
        checkOutput("fill_queue_drained", fill_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
